// File: rtl/lsu_mem_ctrl_if.sv
// CPU-side request/response bundle for the load/store controller.
// master = CPU memory stage, slave = lsu_mem_ctrl.
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: CPU byte-addressed byte/half/word requests to a
// word-addressed RAM with combinational read. Sub-word stores are done as
// read-modify-write. Optional counters enabled by LSU_STATS_EN.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_mem_ctrl_if.slave     cpu,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_errors
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W+1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state;
  req_t              req;
  logic              ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;

  logic              accept;
  logic              req_err;
  logic [3:0]        lane_en;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_data;

  assign cpu.req_ready  = ready_q;
  assign cpu.resp_valid = resp_valid_q;
  assign cpu.resp_err   = resp_err_q;
  assign cpu.resp_rdata = resp_rdata_q;

  assign accept = cpu.req_valid && ready_q;

  // Rejection rules evaluated on the raw request during the accept cycle
  assign req_err = (cpu.req_size == SZ_ILL)
                || (cpu.req_size == SZ_HALF && cpu.req_addr[0])
                || (cpu.req_size == SZ_WORD && cpu.req_addr[1:0] != 2'b00)
                || (|cpu.req_addr[31:ADDR_W+2]);

  // Write strobe from registered state and latched request only, so no
  // combinational path from CPU inputs reaches the RAM enable
  assign ram_we = (state == WRITE)
               || (state == ACCESS && req.we && req.size == SZ_WORD);

  // Per-byte-lane merge of the store data into the old word
  for (genvar i = 0; i < 4; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    logic [7:0] src;
    assign lane_en[i] = (req.size == SZ_BYTE) ? (req.addr[1:0] == LANE)
                                              : (req.addr[1] == LANE[1]);
    assign src = (req.size == SZ_BYTE) ? req.wdata[7:0] : req.wdata[8*(i%2) +: 8];
    assign merged[8*i +: 8] = lane_en[i] ? src : ram_read_data[8*i +: 8];
  end

  // Lane select and sign/zero extension of the word read in ACCESS
  assign shifted = ram_read_data >> {req.addr[1:0], 3'b000};

  // Load result formatting
  always_comb begin
    load_data = ram_read_data;
    case (req.size)
      SZ_BYTE: load_data = {{24{~req.uns & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{~req.uns & shifted[15]}}, shifted[15:0]};
      default: load_data = ram_read_data;
    endcase
  end

  // Main FSM with all handshake and RAM-side outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req            <= '0;
      ready_q        <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_rdata_q   <= '0;
      ram_address    <= '0;
      ram_write_data <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ready_q   <= 1'b0;
            req.we    <= cpu.req_we;
            req.size  <= cpu.req_size;
            req.uns   <= cpu.req_unsigned;
            req.addr  <= cpu.req_addr[ADDR_W+1:0];
            req.wdata <= cpu.req_wdata;
            if (req_err) begin
              // Rejected: straight to RESP, RAM side untouched
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state       <= ACCESS;
              ram_address <= cpu.req_addr[ADDR_W+1:2];
              if (cpu.req_we && cpu.req_size == SZ_WORD)
                ram_write_data <= cpu.req_wdata;
            end
          end
        end
        ACCESS: begin
          if (req.we && req.size != SZ_WORD) begin
            // Old word is on ram_read_data now; stage merged word for WRITE
            state          <= WRITE;
            ram_write_data <= merged;
          end else begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= req.we ? '0 : load_data;
          end
        end
        WRITE: begin
          state        <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        RESP: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSU_STATS_EN
  // Completion counters, bumped once per response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errors <= '0;
    end else if (state == RESP) begin
      if (resp_err_q)  stat_errors <= stat_errors + 32'd1;
      else if (req.we) stat_stores <= stat_stores + 32'd1;
      else             stat_loads  <= stat_loads + 32'd1;
    end
  end
`else
  assign stat_loads  = '0;
  assign stat_stores = '0;
  assign stat_errors = '0;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed plan steps followed by
// randomized requests against a byte-level reference model of the RAM.
module tb_lsu_mem_ctrl;
  localparam int ADDR_W = 11;
  localparam int WORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_write_data;
  logic [31:0]       ram_read_data;
  logic [31:0]       stat_loads, stat_stores, stat_errors;

  lsu_mem_ctrl_if bus();

  lsu_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cpu(bus),
    .ram_we(ram_we), .ram_address(ram_address),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
    .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errors(stat_errors)
  );

  always #5 clk = ~clk;

  // RAM under the DUT, with a backdoor write port used only during reset
  logic [31:0]       mem [0:WORDS-1];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [31:0]       bd_data = '0;
  assign ram_read_data = mem[ram_address];
  always @(posedge clk) begin
    if (ram_we)     mem[ram_address] <= ram_write_data;
    else if (bd_we) mem[bd_addr]     <= bd_data;
  end

  // Reference state
  bit [31:0] ref_mem [0:WORDS-1];
  int m_loads, m_stores, m_errors;
  int n_tests, n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one request computed from the byte-addressed rules
  function automatic void model(input bit we, input bit [1:0] sz, input bit uns,
                                input bit [31:0] a, input bit [31:0] wd,
                                output bit err, output bit [31:0] rd,
                                output int lat, output int nwe, output bit [31:0] nword);
    bit [31:0] old, mask;
    int sh;
    err = (sz == 3) || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0)
       || (a >= (32'd4 << ADDR_W));
    rd = 0; nword = 0; nwe = 0;
    if (err) begin lat = 1; return; end
    old = ref_mem[a[ADDR_W+1:2]];
    sh  = 8 * int'(a % 4);
    mask = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    if (!we) begin
      lat = 2;
      rd = (old >> sh) & mask;
      if (!uns && sz == 0 && rd[7])  rd = rd | 32'hFFFF_FF00;
      if (!uns && sz == 1 && rd[15]) rd = rd | 32'hFFFF_0000;
    end else begin
      nwe = 1;
      lat = (sz == 2) ? 2 : 3;
      nword = (old & ~(mask << sh)) | ((wd & mask) << sh);
    end
  endfunction

  task automatic do_req(input bit we, input bit [1:0] sz, input bit uns,
                        input bit [31:0] a, input bit [31:0] wd, input string tag);
    bit e; bit [31:0] rd, nw; int lat_x, nwe_x;
    int lat, nwe; bit got; logic [31:0] wa, wdat;
    model(we, sz, uns, a, wd, e, rd, lat_x, nwe_x, nw);
    @(negedge clk);
    check({tag, " ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1; nwe = 0; got = 0; wa = 0; wdat = 0;
    for (int k = 0; k < 8; k++) begin
      if (ram_we) begin nwe++; wa = 32'(ram_address); wdat = ram_write_data; end
      if (bus.resp_valid) begin got = 1; break; end
      check({tag, " busy_ready"}, {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
    check({tag, " resp_seen"}, {31'd0, got}, 32'd1);
    check({tag, " latency"}, lat, lat_x);
    check({tag, " err"}, {31'd0, bus.resp_err}, {31'd0, e});
    check({tag, " rdata"}, bus.resp_rdata, rd);
    check({tag, " we_cycles"}, nwe, nwe_x);
    if (nwe_x != 0) begin
      check({tag, " we_addr"}, wa, 32'(a[ADDR_W+1:2]));
      check({tag, " we_data"}, wdat, nw);
    end
    if (e) m_errors++;
    else if (we) begin m_stores++; ref_mem[a[ADDR_W+1:2]] = nw; end
    else m_loads++;
  endtask

  initial begin
    bit [31:0] v, a;
    bit [1:0]  sz;
    int r, diffs;
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0;
    bus.req_unsigned = 0; bus.req_addr = 0; bus.req_wdata = 0;
    n_tests = 0; n_fail = 0; m_loads = 0; m_stores = 0; m_errors = 0;

    // Preload RAM through the backdoor while the DUT is held in reset
    for (int i = 0; i < WORDS; i++) begin
      v = (i == 3) ? 32'h8899_AABB : $urandom;
      ref_mem[i] = v;
      @(negedge clk);
      bd_we = 1'b1; bd_addr = ADDR_W'(i); bd_data = v;
    end
    @(negedge clk);
    bd_we = 1'b0;

    // Reset state
    check("rst ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst resp_err", {31'd0, bus.resp_err}, 32'd0);
    check("rst resp_rdata", bus.resp_rdata, 32'd0);
    check("rst ram_we", {31'd0, ram_we}, 32'd0);
    check("rst ram_address", 32'(ram_address), 32'd0);
    check("rst ram_wdata", ram_write_data, 32'd0);
    check("rst stat_errors", stat_errors, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed plan
    do_req(0, 2'b00, 0, 32'h0000_000D, 32'h0, "lb_s_D");
    do_req(0, 2'b01, 1, 32'h0000_000E, 32'h0, "lh_u_E");
    do_req(0, 2'b01, 0, 32'h0000_000C, 32'h0, "lh_s_C");
    do_req(1, 2'b00, 0, 32'h0000_000F, 32'h1234_565C, "sb_F");
    do_req(0, 2'b10, 0, 32'h0000_000C, 32'h0, "lw_C");
    do_req(1, 2'b10, 0, 32'h0000_0010, 32'hDEAD_BEEF, "sw_10");
    do_req(0, 2'b10, 0, 32'h0000_0010, 32'h0, "lw_10");
    check("lw_C value", ref_mem[3], 32'h5C99_AABB);
    do_req(0, 2'b01, 0, 32'h0000_0001, 32'h0, "err_lh_1");
    do_req(1, 2'b10, 0, 32'h0000_0002, 32'h0BAD_0BAD, "err_sw_2");
    do_req(0, 2'b11, 0, 32'h0000_0008, 32'h0, "err_size");
    do_req(0, 2'b00, 0, 32'h0000_2000, 32'h0, "err_range");
    @(negedge clk);
`ifdef LSU_STATS_EN
    check("stat_errors 4", stat_errors, 32'd4);
`endif

    // Reset during the WRITE cycle of a half store at 0x4
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2'b01;
    bus.req_unsigned = 0; bus.req_addr = 32'h4; bus.req_wdata = 32'h0000_1357;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 0;
    check("abort access we", {31'd0, ram_we}, 32'd0);
    @(negedge clk);
    check("abort write we", {31'd0, ram_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort we drop", {31'd0, ram_we}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    r = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.resp_valid) r++;
    end
    check("abort no resp", r, 0);
    check("abort word1", mem[1], ref_mem[1]);
    check("abort ready", {31'd0, bus.req_ready}, 32'd1);
    m_loads = 0; m_stores = 0; m_errors = 0;

    // Randomized traffic
    for (int n = 0; n < 120; n++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 8191);
      if ($urandom_range(0, 3) != 0)
        a = a & ~((sz == 2'b10) ? 32'd3 : (sz == 2'b01) ? 32'd1 : 32'd0);
      if ($urandom_range(0, 15) == 0)
        a = a | (32'd1 << $urandom_range(13, 31));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, "rnd");
    end
    @(negedge clk);

    diffs = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("mem final", diffs, 0);
`ifdef LSU_STATS_EN
    check("stat_loads", stat_loads, m_loads);
    check("stat_stores", stat_stores, m_stores);
    check("stat_errors", stat_errors, m_errors);
`else
    check("stat_loads tied", stat_loads, 32'd0);
    check("stat_stores tied", stat_stores, 32'd0);
    check("stat_errors tied", stat_errors, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller between the CPU memory stage and the word-addressed data RAM (11-bit word address, single write enable, combinational read).
- Converts CPU byte-addressed requests (byte/half/word, signed/unsigned loads) into RAM word accesses.
- Sub-word stores use a read-modify-write sequence.
- Flags misaligned, illegal-size and out-of-range requests.

Parameters:
ADDR_W, 11, RAM word-address width; valid byte addresses 0 .. (4<<ADDR_W)-1
DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  CPU request valid
req_ready  output  1  controller can accept a request
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  request rejected; qualified by resp_valid
resp_rdata  output  32  formatted load data; qualified by resp_valid
ram_we  output  1  RAM write enable
ram_address  output  ADDR_W  RAM word address
ram_write_data  output  32  RAM write data
ram_read_data  input  32  RAM combinational read data
stat_loads  output  32  completed load count (optional feature)
stat_stores  output  32  completed store count (optional feature)
stat_errors  output  32  error response count (optional feature)

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; ram_we=0; ram_address=0; ram_write_data=0; all request latches 0.
- Handshake: accept when req_valid && req_ready. req_ready=1 only in IDLE. On accept, latch we/size/unsigned/addr/wdata. The CPU must not change inputs after accept. No response backpressure: resp_valid is a single-cycle pulse in RESP.
- Error check, done in IDLE on the accept cycle. Error if any of:
  - size==11
  - half with addr[0]=1
  - word with addr[1:0]!=00
  - addr[31:ADDR_W+2] != 0
  - On error: IDLE->RESP, resp_err=1, ram_we never asserts, no RAM state change.
- States: IDLE, ACCESS, WRITE, RESP.
- ram_address = latched addr[ADDR_W+1:2] in ACCESS and WRITE; holds its last value otherwise.
- ram_we is decoded from registered state only (glitch-free):
  - 1 in ACCESS for word stores
  - 1 in WRITE for sub-word stores
  - 0 in all other states
- Load path: IDLE->ACCESS->RESP.
  - In ACCESS, capture ram_read_data, select the lane by addr[1:0] (byte) or addr[1] (half), then extend per req_unsigned into a result register.
  - Latency from accept to resp_valid is 2 cycles.
- Word store path: IDLE->ACCESS (ram_we=1, ram_write_data=wdata)->RESP. Latency 2 cycles.
- Sub-word store path: IDLE->ACCESS->WRITE->RESP. Latency 3 cycles.
  - ACCESS: capture old word.
  - WRITE: ram_write_data = old word with the addressed byte/half replaced by wdata[7:0]/wdata[15:0]; all other lanes unchanged.
- RESP:
  - resp_valid=1.
  - resp_rdata holds the load result; it is 0 for stores and errors.
  - Next state IDLE; req_ready returns to 1 the following cycle.
  - resp_rdata and resp_err hold their values until the next RESP.
- Back-to-back: a new request can be accepted on the cycle after RESP (IDLE).
- Reset mid-operation: asynchronous return to IDLE.
  - ram_we drops immediately.
  - Any partially completed RMW is abandoned; the RAM keeps the old word.
  - No resp_valid for the aborted request.

Optional Feature:
- LSU_STATS_EN defined:
  - Three 32-bit counters, reset to 0, wrapping at 2^32.
  - In RESP: stat_loads increments for successful loads; stat_stores for successful stores; stat_errors for error responses.
- Not defined: counter logic absent; the stat_* ports remain and are tied to 0.

Test Plan:
- Preload RAM word 3 = 0x8899AABB; signed byte load at 0x0000000D -> resp_rdata=0xFFFFFFAA, resp_err=0, resp_valid 2 cycles after accept, ram_we stays 0.
- Unsigned half load at 0x0000000E -> 0x00008899; signed half load at 0x0000000C -> 0xFFFFAABB.
- Byte store of 0x5C at 0x0000000F -> ram_we high exactly one cycle (WRITE) with ram_address=3 and ram_write_data=0x5C99AABB; resp_valid 3 cycles after accept; word load at 0xC then returns 0x5C99AABB.
- Word store of 0xDEADBEEF at 0x00000010, then an immediately following word load at 0x10 -> ram_we high only in ACCESS; load returns 0xDEADBEEF; req_ready low during ACCESS/RESP.
- Half load at 0x00000001, word store at 0x00000002, size=11, and byte load at 0x00002000 -> each gives resp_err=1 one cycle after accept, ram_we never asserts, RAM unchanged; with LSU_STATS_EN, stat_errors=4.
- Assert rst_n=0 during WRITE of a half store at 0x4 -> ram_we drops asynchronously; word 1 unchanged; no resp_valid; req_ready=1 after release.
